// File: rtl/reg_dump_reader.sv
// ============================================================================
// Module      : reg_dump_reader
// Description : Walks a (wrapping) range of a 16-entry x 16-bit register file
//               and streams each register as three bytes over a valid/ready
//               byte interface: {HDR_TAG, index}, data[15:8], data[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_reader #(
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  first_addr,
    input  logic [3:0]  last_addr,
    output logic [3:0]  ra,
    input  logic [15:0] rd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  last_q, last_d;
    logic [15:0] snap_q, snap_d;
    logic [1:0]  idx_q, idx_d;

    // State and datapath registers; reset aborts any dump in progress at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ra_q    <= 4'd0;
            last_q  <= 4'd0;
            snap_q  <= 16'd0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            last_q  <= last_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: IDLE -> READ -> SEND (x3 bytes) -> READ ... -> DONE.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        last_d  = last_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d    = first_addr;
                    last_d  = last_addr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Snapshot taken here only, so later register writes cannot
                // corrupt bytes already queued for this register.
                snap_d  = rd;
                idx_d   = 2'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q == 2'd2) begin
                        if (ra_q == last_q) begin
                            state_d = S_DONE;
                        end else begin
                            ra_d    = ra_q + 4'd1;
                            state_d = S_READ;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: the byte mux is gated so out_data is zero outside SEND.
    always_comb begin
        out_data = 8'd0;
        if (state_q == S_SEND) begin
            case (idx_q)
                2'd0:    out_data = {HDR_TAG, ra_q};
                2'd1:    out_data = snap_q[15:8];
                default: out_data = snap_q[7:0];
            endcase
        end
    end

    assign ra        = ra_q;
    assign out_valid = (state_q == S_SEND);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// ============================================================================
// Module      : tb_reg_dump_reader
// Description : Scoreboard bench for reg_dump_reader. Expected bytes are
//               queued when a dump is issued; a monitor pops and compares
//               every byte the DUT transfers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  first_addr;
    logic [3:0]  last_addr;
    logic [3:0]  ra;
    logic [15:0] rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [15:0] regs [16];
    logic [7:0]  exp_q [$];
    int          n_cmp;
    int          n_err;
    int          n_bytes;
    int          done_cnt;

    reg_dump_reader #(.HDR_TAG(4'hA)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .ra         (ra),
        .rd         (rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // Register file model: combinational read port.
    assign rd = regs[ra];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_bytes++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_byte: got %0h, expected none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL byte_stream: got %0h, expected %0h", out_data, e);
                end
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    // Queue the expected byte stream for a dump of first..last (wrapping).
    task automatic push_expect(input logic [3:0] f, input logic [3:0] l);
        logic [3:0] d;
        logic [3:0] a;
        d = l - f;
        for (int k = 0; k <= int'(d); k++) begin
            a = f + 4'(k);
            exp_q.push_back({4'hA, a});
            exp_q.push_back(regs[a][15:8]);
            exp_q.push_back(regs[a][7:0]);
        end
    endtask

    task automatic start_dump(input logic [3:0] f, input logic [3:0] l);
        @(posedge clk); #1;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
        @(negedge clk);
        chk({name, "_done_pulse_1cyc"}, {31'd0, done}, 32'd0);
        chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic any_busy;
        logic found;
        n_cmp = 0; n_err = 0; n_bytes = 0; done_cnt = 0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h1111 * 16'(i);
        regs[0]    = 16'h0000;
        rst_n      = 1'b0;
        start      = 1'b0;
        first_addr = 4'd0;
        last_addr  = 4'd0;
        out_ready  = 1'b1;
        #3;
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("rst_done",     {31'd0, done},      32'd0);
        chk("rst_ra",       {28'd0, ra},        32'd0);
        chk("rst_out_data", {24'd0, out_data},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single register, latency and consecutive bytes.
        regs[1] = 16'h1234;
        push_expect(4'd1, 4'd1);
        start_dump(4'd1, 4'd1);
        chk("lat_read_busy",  {31'd0, busy},      32'd1);
        chk("lat_read_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_send_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_send_hdr",   {24'd0, out_data},  32'h0A1);
        wait_done("one_reg");

        // Wrapping range 14..1.
        regs[14] = 16'hAAAA; regs[15] = 16'h5555; regs[1] = 16'h0F0F;
        n_bytes = 0;
        push_expect(4'd14, 4'd1);
        start_dump(4'd14, 4'd1);
        wait_done("wrap");
        chk("wrap_bytes", n_bytes, 32'd12);

        // Back-pressure while index 1 is pending.
        regs[1] = 16'h1234;
        push_expect(4'd1, 4'd1);
        start_dump(4'd1, 4'd1);
        @(posedge clk); #1;            // SEND, byte 0 shown; transfers next edge
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data",  {24'd0, out_data},  32'h12);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("stall");

        // Start pulsed mid-dump must be ignored.
        d0 = done_cnt;
        push_expect(4'd2, 4'd4);
        start_dump(4'd2, 4'd4);
        repeat (4) @(posedge clk);
        #1; first_addr = 4'd9; last_addr = 4'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done("restart");
        any_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) any_busy = 1'b1;
        end
        chk("restart_no_requeue", {31'd0, any_busy}, 32'd0);
        chk("restart_done_count", done_cnt - d0, 32'd1);

        // Reset during the second register of a 3-register dump.
        push_expect(4'd5, 4'd5);         // only register 5 completes
        d0 = done_cnt;
        start_dump(4'd5, 4'd7);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (ra == 4'd6 && out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reached_reg6", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy",  {31'd0, busy},      32'd0);
        chk("abort_queue_empty", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        push_expect(4'd5, 4'd7);
        start_dump(4'd5, 4'd7);
        wait_done("after_abort");

        // Full 0..15 dump with register 3 rewritten during its SEND.
        n_bytes = 0;
        push_expect(4'd0, 4'd15);
        fork
            begin
                start_dump(4'd0, 4'd15);
                wait_done("full");
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk); #2;
                    if (ra == 4'd3 && out_valid) begin
                        regs[3] = 16'hDEAD;
                        break;
                    end
                end
            end
        join
        chk("full_bytes", n_bytes, 32'd48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
